// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared owner codes, FSM encoding, RTC register map and arbitration helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtc_pkg;

  // Bus owner codes as reported on grant
  localparam logic [1:0] OWN_INIT = 2'd0;
  localparam logic [1:0] OWN_RST  = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam logic [1:0] OWN_POLL = 2'd3;

  // Arbiter FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // RTC register map: the time/date block swept by the poller, plus the transfer register
  localparam logic [7:0] RTC_SEC  = 8'h21;
  localparam logic [7:0] RTC_MIN  = 8'h22;
  localparam logic [7:0] RTC_HOUR = 8'h23;
  localparam logic [7:0] RTC_DATE = 8'h24;
  localparam logic [7:0] RTC_MON  = 8'h25;
  localparam logic [7:0] RTC_YEAR = 8'h26;
  localparam logic [7:0] RTC_WDAY = 8'h27;
  localparam logic [7:0] RTC_XFER = 8'hF0;

  // Result of one arbitration round
  typedef struct packed {
    logic       vld;
    logic [1:0] owner;
  } pick_t;

  // Transaction captured in ARB and presented to the engine
  typedef struct packed {
    logic [1:0] owner;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } xact_t;

  // Fixed priority: init > rst > wr > poll
  function automatic pick_t pick_owner(input logic init_r, input logic rst_r,
                                       input logic wr_r, input logic poll_r);
    pick_t p;
    p.vld = init_r | rst_r | wr_r | poll_r;
    if (init_r)      p.owner = OWN_INIT;
    else if (rst_r)  p.owner = OWN_RST;
    else if (wr_r)   p.owner = OWN_WR;
    else             p.owner = OWN_POLL;
    return p;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester, protocol-engine and read-back signals of the RTC bus arbiter.
// Latency: n/a (wiring only).
// Backpressure: level requests held until ack/err; engine paced by start/done pulses.
interface rtc_bus_arbiter_if;

  // Requesters
  logic       init_req;
  logic       rst_req;
  logic       wr_req;
  logic [7:0] init_addr;
  logic [7:0] rst_addr;
  logic [7:0] wr_addr;
  logic [7:0] init_data;
  logic [7:0] rst_data;
  logic [7:0] wr_data;
  logic       init_ack;
  logic       rst_ack;
  logic       wr_ack;
  logic       poll_en;

  // Protocol engine
  logic       proto_start;
  logic       proto_rw;
  logic [7:0] proto_addr;
  logic [7:0] proto_data;
  logic       proto_done;
  logic [7:0] proto_rdata;

  // Poll read-back to the display register file
  logic       rd_valid;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  // Status
  logic [1:0] grant;
  logic       busy;
  logic       err;

  // Arbiter side
  modport master (
    input  init_req, rst_req, wr_req,
    input  init_addr, rst_addr, wr_addr,
    input  init_data, rst_data, wr_data,
    input  poll_en, proto_done, proto_rdata,
    output init_ack, rst_ack, wr_ack,
    output proto_start, proto_rw, proto_addr, proto_data,
    output rd_valid, rd_addr, rd_data,
    output grant, busy, err
  );

  // Requester / engine side
  modport slave (
    output init_req, rst_req, wr_req,
    output init_addr, rst_addr, wr_addr,
    output init_data, rst_data, wr_data,
    output poll_en, proto_done, proto_rdata,
    input  init_ack, rst_ack, wr_ack,
    input  proto_start, proto_rw, proto_addr, proto_data,
    input  rd_valid, rd_addr, rd_data,
    input  grant, busy, err
  );

endinterface

// File: rtl/rtc_bus_arbiter_poll_timer.sv
// Periodic poll scheduler: period counter, sweep-pending flag and read index.
// Latency: pending rises the cycle after the counter wraps; idx advances the cycle after poll_ack.
// Backpressure: wraps while a sweep is pending are dropped; the sweep waits on the arbiter via poll_ack.
module rtc_poll_timer #(
  parameter int unsigned RD_PERIOD = 1_000_000,
  parameter int unsigned RD_COUNT  = 7
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       poll_en,
  input  logic       poll_ack,
  output logic       poll_pending,
  output logic [7:0] poll_idx
);

  localparam int unsigned CW = (RD_PERIOD > 1) ? $clog2(RD_PERIOD) : 1;

  logic [CW-1:0] period_cnt;
  logic          period_wrap;
  logic          sweep_done;

  assign period_wrap = (period_cnt == CW'(RD_PERIOD - 1));
  // Last read of the sweep has just finished (completed or timed out)
  assign sweep_done  = poll_ack && (poll_idx == 8'(RD_COUNT - 1));

  // Free-running period counter, parked at zero while polling is disabled
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      period_cnt <= '0;
    end else if (!poll_en || period_wrap) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Sweep bookkeeping: a wrap arms a sweep, each finished read steps idx, the last one disarms
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      poll_pending <= 1'b0;
      poll_idx     <= '0;
    end else if (!poll_en) begin
      poll_pending <= 1'b0;
      poll_idx     <= '0;
    end else if (poll_ack && poll_pending) begin
      // An ack from a read started before a disable/enable toggle is ignored above
      if (sweep_done) begin
        poll_pending <= 1'b0;
        poll_idx     <= '0;
      end else begin
        poll_idx     <= poll_idx + 8'd1;
      end
    end else if (period_wrap) begin
      poll_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Shares the RTC protocol engine between init/rst/wr requesters and the register poller.
// Latency: request to proto_start 2 cycles; proto_done to ack/rd_valid 1 cycle; done to next start 4 cycles.
// Backpressure: one transaction at a time; requests wait at level, poll sweeps yield between reads.
module rtc_bus_arbiter #(
  parameter int unsigned RD_PERIOD = 1_000_000,
  parameter logic [7:0]  RD_BASE   = 8'h21,
  parameter int unsigned RD_COUNT  = 7,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic               clk,
  input logic               Reset,
  rtc_bus_arbiter_if.master bus
);

  import rtc_pkg::*;

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    state;
  logic [TW-1:0] tcnt;
  logic          tmo_hit;
  logic          poll_ack;
  logic          poll_pending;
  logic [7:0]    poll_idx;
  logic          poll_want;
  logic          any_req;
  pick_t         pick;
  xact_t         nxt;

  rtc_poll_timer #(
    .RD_PERIOD (RD_PERIOD),
    .RD_COUNT  (RD_COUNT)
  ) u_poll_timer (
    .clk          (clk),
    .Reset        (Reset),
    .poll_en      (bus.poll_en),
    .poll_ack     (poll_ack),
    .poll_pending (poll_pending),
    .poll_idx     (poll_idx)
  );

  // A pending sweep only competes while polling is still enabled
  assign poll_want = poll_pending & bus.poll_en;
  assign any_req   = bus.init_req | bus.rst_req | bus.wr_req | poll_want;
  assign pick      = pick_owner(bus.init_req, bus.rst_req, bus.wr_req, poll_want);
  // tcnt is zero in ISSUE and steps every cycle after, so expiry lands TIMEOUT cycles after proto_start
  assign tmo_hit   = (tcnt == TW'(TIMEOUT - 1));

  // Build the transaction the winning owner would launch
  always_comb begin
    nxt.owner = pick.owner;
    nxt.rw    = 1'b0;
    nxt.addr  = bus.wr_addr;
    nxt.data  = bus.wr_data;
    case (pick.owner)
      OWN_INIT: begin
        nxt.addr = bus.init_addr;
        nxt.data = bus.init_data;
      end
      OWN_RST: begin
        nxt.addr = bus.rst_addr;
        nxt.data = bus.rst_data;
      end
      OWN_POLL: begin
        nxt.rw   = 1'b1;
        nxt.addr = RD_BASE + poll_idx;
        nxt.data = 8'h00;
      end
      default: ;
    endcase
  end

  // Arbiter FSM with all bus-facing outputs registered
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state           <= ST_IDLE;
      tcnt            <= '0;
      poll_ack        <= 1'b0;
      bus.init_ack    <= 1'b0;
      bus.rst_ack     <= 1'b0;
      bus.wr_ack      <= 1'b0;
      bus.proto_start <= 1'b0;
      bus.proto_rw    <= 1'b0;
      bus.proto_addr  <= '0;
      bus.proto_data  <= '0;
      bus.rd_valid    <= 1'b0;
      bus.rd_addr     <= '0;
      bus.rd_data     <= '0;
      bus.grant       <= OWN_INIT;
      bus.busy        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      // Single-cycle pulses
      poll_ack        <= 1'b0;
      bus.init_ack    <= 1'b0;
      bus.rst_ack     <= 1'b0;
      bus.wr_ack      <= 1'b0;
      bus.proto_start <= 1'b0;
      bus.rd_valid    <= 1'b0;
      bus.err         <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (any_req) state <= ST_ARB;
        end

        ST_ARB: begin
          // The request that woke us may have been withdrawn; go back quietly
          if (pick.vld) begin
            bus.grant       <= nxt.owner;
            bus.proto_rw    <= nxt.rw;
            bus.proto_addr  <= nxt.addr;
            bus.proto_data  <= nxt.data;
            bus.proto_start <= 1'b1;
            bus.busy        <= 1'b1;
            tcnt            <= '0;
            state           <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          tcnt  <= tcnt + 1'b1;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // Done is checked first so it wins over a coincident expiry
          if (bus.proto_done) begin
            state <= ST_DONE;
            case (bus.grant)
              OWN_INIT: bus.init_ack <= 1'b1;
              OWN_RST:  bus.rst_ack  <= 1'b1;
              OWN_WR:   bus.wr_ack   <= 1'b1;
              default: begin
                bus.rd_valid <= 1'b1;
                bus.rd_addr  <= bus.proto_addr;
                bus.rd_data  <= bus.proto_rdata;
                poll_ack     <= 1'b1;
              end
            endcase
          end else if (tmo_hit) begin
            // No ack: a held request is simply re-arbitrated; a poll read is skipped
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            poll_ack <= (bus.grant == OWN_POLL);
            state    <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Sequencer and arbiter for the single RTC bus protocol engine. It shares the engine between three external requesters (power-up initialisation, reset-to-defaults, user write) and an internal periodic read poller that sweeps the time/date registers. It sits between those requesters and the protocol engine, replacing ad-hoc address/data muxing. It returns read-back bytes to the display register file.

## Interface
Parameters:
- RD_PERIOD, 1_000_000: clk cycles between poll sweeps (10 ms at 100 MHz).
- RD_BASE, 8'h21: first RTC register address read by a sweep.
- RD_COUNT, 7: registers per sweep (8'h21..8'h27).
- TIMEOUT, 1024: max cycles waiting for proto_done before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- init_req / rst_req / wr_req  in  1 each  level request; held until matching ack or err.
- init_addr, rst_addr, wr_addr  in  8 each  target register; stable while req is high.
- init_data, rst_data, wr_data  in  8 each  write byte; stable while req is high.
- init_ack / rst_ack / wr_ack  out  1 each  one-cycle completion pulse.
- poll_en  in  1  enables the periodic poller.
- proto_start  out  1  one-cycle transaction start pulse to the engine.
- proto_rw  out  1  1 = read, 0 = write.
- proto_addr  out  8  address to the engine.
- proto_data  out  8  write byte to the engine.
- proto_done  in  1  one-cycle engine completion pulse.
- proto_rdata  in  8  read byte; valid in the proto_done cycle.
- rd_valid  out  1  one-cycle pulse: poll read byte available.
- rd_addr  out  8  address of the rd_data byte.
- rd_data  out  8  poll read byte.
- grant  out  2  current owner: 0 init, 1 rst, 2 wr, 3 poll.
- busy  out  1  transaction in progress.
- err  out  1  one-cycle timeout pulse; grant identifies the failing owner.

## Operation
- States: IDLE, ARB, ISSUE, WAIT, DONE.
- IDLE -> ARB when any request is high or poll_pending=1.
- ARB: fixed priority init > rst > wr > poll. Latches grant, addr, data and rw into output registers. All external requesters write (rw=0); poll reads (rw=1).
- ISSUE: proto_start=1 for one cycle, then WAIT.
- WAIT: on proto_done -> DONE. On timeout counter = TIMEOUT-1 -> err pulse, then IDLE with no ack.
- DONE: pulses the granted ack, or for poll: rd_valid, rd_addr, rd_data. Then IDLE.
- Poller: a free-running period counter wraps at RD_PERIOD-1.
  - Each wrap sets poll_pending. Wraps do not accumulate; a wrap while pending is a no-op.
  - A sweep issues RD_COUNT reads, address RD_BASE+idx.
  - idx increments after each completed or timed-out poll read. idx = RD_COUNT-1 done -> clear pending, idx=0.
  - Higher-priority requests preempt between poll reads, never mid-transaction. idx is retained across preemption.
- poll_en=0: counter held at 0, pending cleared, idx=0. An in-flight poll read completes and still pulses rd_valid.
- A requester dropping req before grant is simply not served.
- A requester dropping req during WAIT: the transaction completes and ack still pulses.
- proto_done outside WAIT is ignored.
- busy=1 in ISSUE, WAIT and DONE.

## Timing
- Reset (asserted low): state IDLE. All outputs 0: acks, proto_*, rd_*, grant, busy, err. Counters, idx and pending cleared. Takes effect immediately, including mid-transaction; the engine is not informed.
- Request-to-start latency: 2 cycles (request seen in IDLE, ARB, then proto_start in ISSUE).
- proto_done to ack/rd_valid: 1 cycle (ack in DONE).
- Back-to-back issue gap: DONE -> IDLE -> ARB -> ISSUE. Minimum 4 cycles between proto_done and the next proto_start.
- Timeout counter clears in ISSUE and counts in WAIT.
- Simultaneous proto_done and timeout expiry: done wins, no err.
- All outputs are registered.

## Structure
- Shared package rtc_pkg:
  - owner codes OWN_INIT=0, OWN_RST=1, OWN_WR=2, OWN_POLL=3;
  - state encoding;
  - RTC address constants (RTC_SEC=8'h21 .. RTC_WDAY=8'h27, RTC_XFER=8'hF0).
- Sub-module rtc_poll_timer: period counter, poll_pending, idx, sweep-done. Interface is ack-in / pending-out.
- The arbiter FSM and output registers stay in rtc_bus_arbiter.

## Test plan
- Reset release, poll_en=1, RD_PERIOD=100, engine done 5 cycles after start -> first proto_start at cycle 101. Seven reads, addr 8'h21..8'h27, rw=1. Seven rd_valid pulses with matching rd_addr/rd_data.
- init_req and wr_req raised the same cycle -> init served first (grant=0, init_ack). Then wr (grant=2, wr_ack). proto_rw=0 both times, proto_data equal to each requester's data.
- wr_req raised during poll read idx=3 -> the read completes. Next transaction is wr. Sweep resumes at addr 8'h25.
- Engine never returns done, TIMEOUT=16 -> err pulses 16 cycles after proto_start, no ack, grant unchanged in the err cycle. A still-held request is re-issued.
- Reset asserted during WAIT -> all outputs 0 asynchronously. After release, no ack. A held request restarts from ARB.
- poll_en dropped mid-sweep -> the current read completes with rd_valid. No further poll starts. Re-enable -> sweep restarts at 8'h21 after RD_PERIOD cycles.
